cdrive_sink: RTL and testbench

CDRIVE_SINK -- requirements
Module: cdrive_sink

---
 rtl/cdrive_pkg.sv | 23 ++
 rtl/sync_bit.sv | 27 ++
 rtl/cdrive_sink.sv | 184 ++++++++++++++++++
 tb/tb_cdrive_sink.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cdrive_pkg.sv
// Shared definitions for the click-pipeline drive sink: default sizing,
// free-generator state encoding and the i_drive synchronizer depth.
// Build option: define DRIVE_SYNC3_EN for a 3-flop i_drive synchronizer
// (default is 2 flops).
package cdrive_pkg;

    localparam int DW_DEF     = 32;
    localparam int DEPTH_DEF  = 4;
    localparam int FREE_W_DEF = 2;

`ifdef DRIVE_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    typedef enum logic [1:0] {
        FREE_IDLE  = 2'd0,
        FREE_PULSE = 2'd1,
        FREE_GAP   = 2'd2
    } free_state_t;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchronizer for an asynchronous level input.
// Output reads low while in reset.
module sync_bit
    import cdrive_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdrive_sink.sv
// Click-pipeline drive sink: turns asynchronous i_drive rises into tokens in
// a small FWFT buffer and returns o_free acknowledges, withholding the free
// of the token that fills the buffer until space reappears.
// Build option: DRIVE_SYNC3_EN selects a 3-flop i_drive synchronizer.
module cdrive_sink
    import cdrive_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int FREE_W = FREE_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_drive,
    input  logic [DW-1:0] i_data,
    output logic          o_free,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    input  logic          i_ready,
    output logic          o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = AW + 2;
    localparam int FW = (FREE_W > 1) ? $clog2(FREE_W) : 1;

    // Token ingress
    logic                   drive_sync;
    logic                   drive_prev;
    logic                   armed;
    logic [SYNC_STAGES-1:0] settle_q;
    logic                   push_evt;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_drive),
        .q     (drive_sync)
    );

    // Edge detector; armed only once the synchronizer has flushed after reset
    // and shown a low, so a drive already high at release is not a token.
    // NOTE: state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q   <= '0;
            drive_prev <= 1'b0;
            armed      <= 1'b0;
        end else begin
            settle_q   <= {settle_q[SYNC_STAGES-2:0], 1'b1};
            drive_prev <= drive_sync;
            if (settle_q[SYNC_STAGES-1] && !drive_sync) begin
                armed <= 1'b1;
            end
        end
    end

    assign push_evt = armed && drive_sync && !drive_prev;

    // Token buffer
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_next;
    logic [PW-1:0] occ;
    logic [PW-1:0] occ_next;
    logic          full;
    logic          push_ok;
    logic          pop;
    logic          fills;
    logic          withheld;
    logic [DW-1:0] head_next;

    assign occ       = wr_ptr - rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = o_valid && i_ready;
    assign push_ok   = push_evt && !full;
    assign rd_next   = rd_ptr + PW'(pop);
    assign occ_next  = occ + PW'(push_ok) - PW'(pop);
    assign fills     = push_ok && (occ_next == PW'(DEPTH));
    // The entry being written this cycle becomes head when it lands in front
    // of the next read pointer; bypass it so o_data is ready with o_valid.
    assign head_next = (push_ok && (rd_next == wr_ptr)) ? i_data : mem[rd_next[AW-1:0]];

    // Storage write
    // NOTE: the data array has no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Pointers, registered head, overflow and withheld-free tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_overflow <= 1'b0;
            withheld   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr  <= rd_next;
            o_valid <= (occ_next != '0);
            if (occ_next != '0) begin
                o_data <= head_next;
            end
            if (push_evt && full) begin
                o_overflow <= 1'b1;
            end
            if (fills) begin
                withheld <= 1'b1;
            end else if (pop) begin
                withheld <= 1'b0;
            end
        end
    end

    // Free generator
    free_state_t   free_state;
    logic [CW-1:0] free_cnt;
    logic [FW-1:0] pulse_cnt;
    logic          free_inc;
    logic          free_dec;

    // A fill and a withheld release are mutually exclusive (release needs a
    // full buffer, a fill needs a non-full one), so at most one free per clk.
    assign free_inc = (push_ok && !fills) || (pop && withheld);
    assign free_dec = (free_state == FREE_PULSE) && (pulse_cnt == FW'(FREE_W - 1));

    // Pending-free counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_cnt <= '0;
        end else begin
            free_cnt <= free_cnt + CW'(free_inc) - CW'(free_dec);
        end
    end

    // Pulse shaper: FREE_W-clk high pulses with at least one low clk between
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_state <= FREE_IDLE;
            pulse_cnt  <= '0;
            o_free     <= 1'b0;
        end else begin
            case (free_state)
                FREE_IDLE: begin
                    if (free_cnt != '0) begin
                        free_state <= FREE_PULSE;
                        pulse_cnt  <= '0;
                        o_free     <= 1'b1;
                    end
                end
                FREE_PULSE: begin
                    if (pulse_cnt == FW'(FREE_W - 1)) begin
                        free_state <= FREE_GAP;
                        o_free     <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt + FW'(1);
                    end
                end
                FREE_GAP: begin
                    if (free_cnt != '0) begin
                        free_state <= FREE_PULSE;
                        pulse_cnt  <= '0;
                        o_free     <= 1'b1;
                    end else begin
                        free_state <= FREE_IDLE;
                    end
                end
                default: begin
                    free_state <= FREE_IDLE;
                    o_free     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdrive_sink.sv
// Directed bench for cdrive_sink: latency, free withholding, overflow,
// back-to-back push/pop across pointer wrap, and reset mid-operation.
module tb_cdrive_sink;

    localparam int DW     = 32;
    localparam int DEPTH  = 4;
    localparam int FREE_W = 2;
`ifdef DRIVE_SYNC3_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          i_drive = 1'b0;
    logic          i_ready = 1'b0;
    logic [DW-1:0] i_data  = '0;
    logic          o_free;
    logic          o_valid;
    logic          o_overflow;
    logic [DW-1:0] o_data;

    int checks   = 0;
    int failures = 0;
    int free_pulses = 0;
    logic free_prev = 1'b0;
    logic [DW-1:0] exp_q [$];

    cdrive_sink #(.DW(DW), .DEPTH(DEPTH), .FREE_W(FREE_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_drive    (i_drive),
        .i_data     (i_data),
        .o_free     (o_free),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .i_ready    (i_ready),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    // Count o_free pulses (rising edges seen on the falling clock edge)
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_prev = 1'b0;
        end else begin
            if (o_free && !free_prev) free_pulses++;
            free_prev = o_free;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One token: drive high LAT clks (push lands on the last), low 3 clks.
    // With pop_at_push, i_ready is raised for exactly the push clk.
    task automatic send(input logic [DW-1:0] data, input bit pop_at_push,
                        input logic [DW-1:0] exp_head = '0);
        i_data  = data;
        i_drive = 1'b1;
        repeat (LAT - 1) tick();
        if (pop_at_push) begin
            chk("b2b_head", o_data, exp_head);
            chk("b2b_valid", {31'd0, o_valid}, 32'd1);
            i_ready = 1'b1;
        end
        tick();
        if (pop_at_push) i_ready = 1'b0;
        i_drive = 1'b0;
        repeat (3) tick();
    endtask

    int base;
    logic [DW-1:0] head;

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_free",     {31'd0, o_free},     32'd0);
        chk("rst_valid",    {31'd0, o_valid},    32'd0);
        chk("rst_data",     o_data,              32'd0);
        chk("rst_overflow", {31'd0, o_overflow}, 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Single token, consumer ready
        i_ready = 1'b1;
        i_data  = 32'hA5A5_0001;
        i_drive = 1'b1;
        repeat (LAT - 1) tick();
        chk("t1_valid_early", {31'd0, o_valid}, 32'd0);
        tick();
        chk("t1_valid",    {31'd0, o_valid}, 32'd1);
        chk("t1_data",     o_data,           32'hA5A5_0001);
        chk("t1_free_pre", {31'd0, o_free},  32'd0);
        i_drive = 1'b0;
        tick();
        chk("t1_valid_gone", {31'd0, o_valid}, 32'd0);
        chk("t1_free_hi0",   {31'd0, o_free},  32'd1);
        tick();
        chk("t1_free_hi1",   {31'd0, o_free},  32'd1);
        tick();
        chk("t1_free_lo",    {31'd0, o_free},  32'd0);
        repeat (3) tick();
        chk("t1_pulses", free_pulses, 32'd1);
        i_ready = 1'b0;

        // Fill to DEPTH: three frees, fourth withheld
        base = free_pulses;
        send(32'h1111_0001, 1'b0);
        send(32'h1111_0002, 1'b0);
        send(32'h1111_0003, 1'b0);
        send(32'h1111_0004, 1'b0);
        repeat (4) tick();
        chk("t2_pulses_full", free_pulses - base, 32'd3);
        chk("t2_valid",       {31'd0, o_valid}, 32'd1);
        chk("t2_head",        o_data, 32'h1111_0001);
        chk("t2_no_ovf",      {31'd0, o_overflow}, 32'd0);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("t2_head_after_pop", o_data, 32'h1111_0002);
        chk("t2_valid_after_pop", {31'd0, o_valid}, 32'd1);
        repeat (5) tick();
        chk("t2_withheld_released", free_pulses - base, 32'd4);

        // Refill (withheld again), then one token too many
        send(32'h1111_0005, 1'b0);
        send(32'hDEAD_0006, 1'b0);
        repeat (4) tick();
        chk("t3_overflow",    {31'd0, o_overflow}, 32'd1);
        chk("t3_no_free",     free_pulses - base, 32'd4);
        i_ready = 1'b1;
        chk("t3_drain0", o_data, 32'h1111_0002);
        tick();
        chk("t3_drain1", o_data, 32'h1111_0003);
        tick();
        chk("t3_drain2", o_data, 32'h1111_0004);
        tick();
        chk("t3_drain3", o_data, 32'h1111_0005);
        tick();
        chk("t3_empty", {31'd0, o_valid}, 32'd0);
        i_ready = 1'b0;
        repeat (5) tick();
        chk("t3_ovf_sticky", {31'd0, o_overflow}, 32'd1);
        chk("t3_release_free", free_pulses - base, 32'd5);

        // Back-to-back push with pop in the same clk, crossing pointer wrap
        base = free_pulses;
        exp_q.delete();
        exp_q.push_back(32'hC0DE_0000);
        send(32'hC0DE_0000, 1'b0);
        exp_q.push_back(32'hC0DE_0001);
        send(32'hC0DE_0001, 1'b0);
        for (int k = 2; k < 14; k++) begin
            head = exp_q.pop_front();
            exp_q.push_back(32'hC0DE_0000 + DW'(k));
            send(32'hC0DE_0000 + DW'(k), 1'b1, head);
        end
        chk("t4_valid", {31'd0, o_valid}, 32'd1);
        i_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            head = exp_q.pop_front();
            chk("t4_drain", o_data, head);
            tick();
        end
        chk("t4_empty", {31'd0, o_valid}, 32'd0);
        i_ready = 1'b0;
        repeat (4) tick();
        chk("t4_pulses", free_pulses - base, 32'd14);

        // Reset mid-operation with tokens buffered and a free in flight
        send(32'hF00D_0001, 1'b0);
        send(32'hF00D_0002, 1'b0);
        i_data  = 32'hF00D_0003;
        i_drive = 1'b1;
        repeat (LAT + 1) tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_free",  {31'd0, o_free},     32'd0);
        chk("t5_rst_valid", {31'd0, o_valid},    32'd0);
        chk("t5_rst_data",  o_data,              32'd0);
        chk("t5_rst_ovf",   {31'd0, o_overflow}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        base = free_pulses;
        repeat (8) tick();
        chk("t5_held_no_token", {31'd0, o_valid}, 32'd0);
        chk("t5_no_free",       free_pulses - base, 32'd0);
        i_drive = 1'b0;
        repeat (3) tick();
        i_data  = 32'h5EED_0001;
        i_drive = 1'b1;
        repeat (LAT - 1) tick();
        chk("t5_rearm_early", {31'd0, o_valid}, 32'd0);
        tick();
        chk("t5_rearm_valid", {31'd0, o_valid}, 32'd1);
        chk("t5_rearm_data",  o_data, 32'h5EED_0001);
        i_drive = 1'b0;
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
